// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding and
// the latched memory command.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 10;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_STRB_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_STRB_W-1:0] wstrb;
    } arb_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester that was
// not granted last wins.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       owner
);

    assign grant_valid = |req;

    always_comb begin
        owner = OWNER_CORE;
        if (&req)
            owner = ~last_owner;
        else if (req[OWNER_HOST])
            owner = OWNER_HOST;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory: IDLE->ACCESS->CAPTURE->DONE.
// Define DMEM_ARB_PROT_EN to reject host accesses to [PROT_BASE, PROT_LIMIT].
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int                ADDR_W     = ARB_ADDR_W,
    parameter int                DATA_W     = ARB_DATA_W,
    parameter logic [ADDR_W-1:0] PROT_BASE  = 10'h300,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 10'h3FF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic                c_done,
    output logic [DATA_W-1:0]   c_rdata,
    input  logic                h_req,
    input  logic                h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    input  logic [DATA_W/8-1:0] h_wstrb,
    output logic                h_done,
    output logic [DATA_W-1:0]   h_rdata,
    output logic                h_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state;
    arb_cmd_t   cmd, nxt_cmd;
    logic       last_owner;
    logic       grant_valid, pick_owner;
    logic       block_host;

    rr_pick2 u_pick (
        .req         ({h_req, c_req}),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .owner       (pick_owner)
    );

    always_comb begin
        nxt_cmd.we    = c_we;
        nxt_cmd.addr  = c_addr;
        nxt_cmd.wdata = c_wdata;
        nxt_cmd.wstrb = c_wstrb;
        if (pick_owner == OWNER_HOST) begin
            nxt_cmd.we    = h_we;
            nxt_cmd.addr  = h_addr;
            nxt_cmd.wdata = h_wdata;
            nxt_cmd.wstrb = h_wstrb;
        end
    end

`ifdef DMEM_ARB_PROT_EN
    logic err_q;

    assign block_host = (pick_owner == OWNER_HOST) &&
                        (h_addr >= PROT_BASE) && (h_addr <= PROT_LIMIT);
`else
    assign block_host = 1'b0;
    assign h_err      = 1'b0;
`endif

    // cmd only changes when a real memory cycle is issued, so the memory
    // address/data pins hold across rejected host accesses.
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_wstrb = cmd.wstrb;
    assign mem_we    = mem_en & cmd.we;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cmd        <= '0;
            last_owner <= OWNER_HOST;
            mem_en     <= 1'b0;
            c_done     <= 1'b0;
            h_done     <= 1'b0;
            c_rdata    <= '0;
            h_rdata    <= '0;
`ifdef DMEM_ARB_PROT_EN
            err_q      <= 1'b0;
            h_err      <= 1'b0;
`endif
        end else begin
            mem_en <= 1'b0;
            c_done <= 1'b0;
            h_done <= 1'b0;
`ifdef DMEM_ARB_PROT_EN
            h_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_owner <= pick_owner;
`ifdef DMEM_ARB_PROT_EN
                        err_q      <= block_host;
`endif
                        if (block_host) begin
                            state <= CAPTURE;
                        end else begin
                            cmd    <= nxt_cmd;
                            mem_en <= 1'b1;
                            state  <= ACCESS;
                        end
                    end
                end
                ACCESS: state <= CAPTURE;
                CAPTURE: begin
                    if (last_owner == OWNER_HOST) begin
`ifdef DMEM_ARB_PROT_EN
                        if (err_q)
                            h_rdata <= '0;
                        else if (!cmd.we)
                            h_rdata <= mem_rdata;
                        h_err <= err_q;
`else
                        if (!cmd.we)
                            h_rdata <= mem_rdata;
`endif
                        h_done <= 1'b1;
                    end else begin
                        if (!cmd.we)
                            c_rdata <= mem_rdata;
                        c_done <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port, synchronous-read data memory between the processor's load/store path (core port) and the external host/loader port that drives `data_in`. It sequences every access through a fixed 4-state FSM with two-way round-robin arbitration and returns read data and completion per requester. It sits between the processor's load/store signals and the data memory macro, and optionally enforces a host-inaccessible secure region.

## Interface
- `ADDR_W`, 10, word-address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `PROT_BASE`, 10'h300, first word of the secure region (used only with the macro)
- `PROT_LIMIT`, 10'h3FF, last word of the secure region, inclusive (used only with the macro)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low reset
- `c_req` in 1: core request; held until `c_done`
- `c_we` in 1: core write (1) / read (0)
- `c_addr` in ADDR_W: core word address
- `c_wdata` in DATA_W: core write data
- `c_wstrb` in DATA_W/8: core byte strobes
- `c_done` out 1: one-cycle core completion pulse
- `c_rdata` out DATA_W: core read data, valid with `c_done` and held afterwards
- `h_req`, `h_we`, `h_addr`, `h_wdata`, `h_wstrb`: host equivalents of the core inputs
- `h_done` out 1, `h_rdata` out DATA_W: host equivalents of the core outputs
- `h_err` out 1: host access rejected; valid with `h_done`
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_wstrb` out DATA_W/8: memory port
- `mem_rdata` in DATA_W: memory read data, one cycle after `mem_en`

## Operation
- FSM has four states: IDLE, ACCESS, CAPTURE and DONE.
- IDLE
  - No request: stay in IDLE.
  - Otherwise pick the owner, latch its `we/addr/wdata/wstrb` into a command register, and go to ACCESS.
- Arbitration
  - A lone requester wins.
  - If both request, the requester not granted last wins.
  - `last_owner` updates on each grant.
- ACCESS
  - `mem_en=1` and the `mem_*` outputs are driven from the command register, for exactly one cycle.
  - Then go to CAPTURE.
- CAPTURE
  - `mem_rdata` is registered into the owner's rdata register (reads only; writes leave it unchanged).
  - Then go to DONE.
- DONE
  - The owner's `done` pulses for 1 cycle.
  - Then go to IDLE.
- Request inputs are ignored outside IDLE. A requester keeping `req` high after `done` is treated as a new request, subject to round-robin.
- The non-owner's `done` and rdata are never disturbed.
- Outside ACCESS, `mem_en=0`, `mem_we=0`, and `mem_addr/wdata/wstrb` hold their last value.

## Timing
- Reset values:
  - State IDLE.
  - `c_done=h_done=h_err=0`.
  - `c_rdata=h_rdata=0`.
  - `mem_en=mem_we=0`, `mem_addr/wdata/wstrb=0`.
  - `last_owner=host`, so the core wins the first tie.
- Latency:
  - A request sampled in IDLE at edge N puts `mem_en` high in cycle N+1 and `done` high in cycle N+3.
  - The minimum spacing between accesses is 4 cycles.
- Back-to-back with both requesting continuously: grants alternate core, host, core, and so on.
- Reset during any state: the next cycle is IDLE with reset values. The in-flight access is dropped with no `done`. A write already issued in ACCESS may have reached memory.
- Simultaneous `c_req` and `h_req` in IDLE: exactly one grant. The loser waits at most one full transaction (4 cycles).
- The core stalls externally on `c_req && !c_done`; this block adds no other stall signal.

## Configuration
- Macro: `DMEM_ARB_PROT_EN`.
- Defined:
  - A host request with `PROT_BASE <= h_addr <= PROT_LIMIT` is granted normally.
  - ACCESS is skipped: IDLE goes directly to CAPTURE with `mem_en=0` (no memory cycle).
  - `h_rdata` is loaded with 0, and `h_done` and `h_err` are asserted together in DONE.
  - Core accesses are never checked.
- Undefined: `h_err` is tied to 0, the parameters are unused, and all host accesses reach memory.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, ACCESS, CAPTURE, DONE);
  - the owner encoding `OWNER_CORE=1'b0`, `OWNER_HOST=1'b1`;
  - the command-register struct (`we`, `addr`, `wdata`, `wstrb`).
- One sub-module, `rr_pick2`: a combinational two-way round-robin picker. Inputs `req[1:0]` and `last_owner`; outputs `grant_valid` and `owner`.

## Test plan
- Core read: preload mem[5]=32'hDEADBEEF, `c_req`, `c_we=0`, `c_addr=5`. Expect `mem_en` in cycle 1, `c_done` in cycle 3, `c_rdata=32'hDEADBEEF`, `h_done` never set.
- Host write then core read:
  - Host writes 32'h12345678 to addr 10 with `wstrb=4'b0011`, over old contents 32'hFFFFFFFF.
  - A core read of addr 10 returns 32'hFFFF5678.
- Contention: `c_req` and `h_req` both held for 16 cycles from reset. Expect the grant order core, host, core, host (four `done` pulses, alternating), never both in one cycle.
- Reset mid-op: assert `reset=0` in the ACCESS cycle of a core read. Next cycle expect state IDLE, `mem_en=0`, `c_done=0`, `c_rdata=0`, and no later `c_done` for that request.
- `DMEM_ARB_PROT_EN` defined:
  - Host read of addr 10'h300: `mem_en` never asserted, `h_done=1`, `h_err=1`, `h_rdata=0`.
  - Host read of 10'h2FF: `h_err=0` with real data.
  - Core read of 10'h300 succeeds.
- Macro undefined: a host write of 32'hA5A5A5A5 to 10'h300 lands in memory, confirmed by a core readback, with `h_err=0`.
